wdt_kick_ctrl: RTL
==================

WDT_KICK_CTRL -- requirements
Module: wdt_kick_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 8: service window length in clk cycles; legal range 2..255.
REQ-002 SHALL have parameter NUM_TASKS, default 2: number of monitored tasks; legal range 1..8.
REQ-003 SHALL have parameter KICK_WIDTH, default 2: kick pulse length in cycles; legal range 1..PERIOD-1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  service enable; low forces IDLE.
REQ-007 SHALL have port alive  input  NUM_TASKS  per-task single-cycle check-in pulses.
REQ-008 SHALL have port wdt_reset  input  1  reset indication returned by the watchdog.
REQ-009 SHALL have port kick  output  1  kick to the watchdog, registered.
REQ-010 SHALL have port missed  output  NUM_TASKS  tasks absent in the last failed window.
REQ-011 SHALL have port fault  output  1  sticky flag for a withheld kick.

Function
REQ-012 SHALL implement states IDLE, COLLECT, KICK and HOLD.
REQ-013 IDLE -> COLLECT SHALL occur on the first cycle enable=1; the window counter SHALL start at 0.
REQ-014 In COLLECT and KICK, seen[i] SHALL be set on any cycle alive[i]=1 and SHALL hold until window end.
REQ-015 The window counter SHALL run 0..PERIOD-1 in COLLECT and KICK, wrap to 0, and be $clog2(PERIOD) bits wide with no overflow.
REQ-016 At counter=PERIOD-1, the next state SHALL be evaluated from seen OR alive, so a check-in on the closing cycle counts.
REQ-017 If all bits are set at window end: enter KICK, assert kick for exactly KICK_WIDTH cycles from the next cycle, and clear missed.
REQ-018 If any bit is clear at window end: no kick; missed SHALL load the inverted bits; fault SHALL set; the block SHALL stay in COLLECT.
REQ-019 seen SHALL clear at every window end; alive on the first cycle of a new window SHALL count for that window.
REQ-020 Check-ins arriving during KICK SHALL count toward the current window, since windows run back to back.
REQ-021 KICK -> COLLECT SHALL occur after KICK_WIDTH cycles, with the counter continuing.
REQ-022 wdt_reset=1 while enable=1 SHALL force HOLD next cycle: kick=0, counter=0, seen=0.
REQ-023 HOLD SHALL remain while wdt_reset=1, then go to COLLECT with counter 0.
REQ-024 wdt_reset SHALL take priority over the window-end decision when both occur in the same cycle.
REQ-025 enable=0 SHALL force IDLE next cycle from any state: kick=0, counter=0, seen=0, fault=0, missed=0.
REQ-026 enable=0 SHALL take priority over wdt_reset.
REQ-027 fault SHALL clear only on rst or enable=0; a later successful kick SHALL NOT clear it.

Reset
REQ-028 rst=1 SHALL immediately force: state=IDLE, kick=0, missed=0, fault=0, counter=0, seen=0.
REQ-029 rst asserted mid-kick SHALL truncate the pulse immediately, without waiting for a clock edge.

Configuration
REQ-030 With macro WDT_KICK_STATS_EN defined, the block SHALL add outputs kick_count[7:0] and reset_count[7:0].
REQ-031 kick_count SHALL increment once per kick pulse.
REQ-032 reset_count SHALL increment once per rising edge of wdt_reset.
REQ-033 Both counters SHALL saturate at 255, reset to 0 on rst, and be unaffected by enable.
REQ-034 Without the macro, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-035 Package wdt_pkg SHALL hold the state enum type wdt_kick_state_t and the default constants for PERIOD, NUM_TASKS and KICK_WIDTH.
REQ-036 The window counter with terminal-count output SHALL be one sub-module, wdt_window_cnt; the rest SHALL be flat.

Verification (PERIOD=8, NUM_TASKS=2, KICK_WIDTH=2)
REQ-037 Both tasks pulse alive in cycle 3 of the window -> kick high for 2 cycles starting the cycle after counter=7; missed=00; fault=0.
REQ-038 Only alive[0] pulses -> no kick at window end; missed=10; fault=1; fault stays 1 after a later good window.
REQ-039 alive[1] pulses exactly on counter=7 with alive[0] earlier -> kick is issued.
REQ-040 wdt_reset goes high for 3 cycles on the window-end cycle -> no kick; HOLD for 3 cycles; COLLECT restarts at counter 0.
REQ-041 enable dropped during kick -> kick low next cycle; fault and missed cleared; re-enabling restarts the window at 0.
REQ-042 WDT_KICK_STATS_EN defined, 300 good windows -> kick_count saturates at 255; two wdt_reset pulses -> reset_count=2.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and default constants for the watchdog kick controller.
// Contents:
//   wdt_kick_state_t     - controller state encoding
//   WDT_PERIOD_DEF       - default service window length in clk cycles
//   WDT_NUM_TASKS_DEF    - default number of monitored tasks
//   WDT_KICK_WIDTH_DEF   - default kick pulse length in clk cycles
package wdt_pkg;

  localparam int WDT_PERIOD_DEF     = 8;
  localparam int WDT_NUM_TASKS_DEF  = 2;
  localparam int WDT_KICK_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    KICK    = 2'd2,
    HOLD    = 2'd3
  } wdt_kick_state_t;

endpackage

// File: rtl/wdt_window_cnt.sv
// Service window counter: counts 0..PERIOD-1 and wraps, with a terminal-count
// flag on the last cycle of the window.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (counter to 0)
//   clr  - synchronous clear to 0, dominates en
//   en   - advance the counter this cycle
//   cnt  - current count
//   tc   - high while cnt == PERIOD-1
module wdt_window_cnt #(
  parameter int PERIOD = 8,
  parameter int CW     = $clog2(PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign tc = (cnt_reg == CW'(PERIOD - 1));

  // Explicit wrap at PERIOD-1 keeps non-power-of-two periods in range.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = tc ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/wdt_kick_ctrl.sv
// Watchdog kick controller: collects per-task check-ins over a fixed window
// and issues a registered kick pulse to an external watchdog only when every
// task checked in during that window. A failed window withholds the kick,
// records the absent tasks and sets a sticky fault flag.
// Ports:
//   clk         - clock
//   rst         - asynchronous active-high reset
//   enable      - service enable; low returns to IDLE and clears status
//   alive       - per-task check-in pulses
//   wdt_reset   - reset indication from the watchdog; holds the controller
//   kick        - kick pulse to the watchdog (registered)
//   missed      - tasks absent in the last failed window
//   fault       - sticky: a kick has been withheld
//   kick_count  - saturating count of kick pulses     (WDT_KICK_STATS_EN only)
//   reset_count - saturating count of wdt_reset rises (WDT_KICK_STATS_EN only)
// Build option: define WDT_KICK_STATS_EN to add the statistics counters.
module wdt_kick_ctrl
  import wdt_pkg::*;
#(
  parameter int PERIOD     = WDT_PERIOD_DEF,
  parameter int NUM_TASKS  = WDT_NUM_TASKS_DEF,
  parameter int KICK_WIDTH = WDT_KICK_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_TASKS-1:0] alive,
  input  logic                 wdt_reset,
  output logic                 kick,
  output logic [NUM_TASKS-1:0] missed,
  output logic                 fault
`ifdef WDT_KICK_STATS_EN
  ,
  output logic [7:0]           kick_count,
  output logic [7:0]           reset_count
`endif
);

  localparam int CW = $clog2(PERIOD);

  wdt_kick_state_t      state_reg, state_next;
  logic [NUM_TASKS-1:0] seen_reg;
  logic [NUM_TASKS-1:0] missed_reg;
  logic                 fault_reg;
  logic                 kick_reg;
  logic [CW-1:0]        cnt;
  logic                 tc;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [NUM_TASKS-1:0] seen_now;
  logic                 all_seen;
  logic                 win_end;

  // A check-in on the closing cycle still counts toward the window.
  assign seen_now = seen_reg | alive;
  assign all_seen = &seen_now;

  assign cnt_en  = (state_reg == COLLECT) || (state_reg == KICK);
  assign cnt_clr = !enable || wdt_reset || (state_reg == IDLE) || (state_reg == HOLD);

  // Window-end decision only applies when nothing higher-priority intervenes.
  assign win_end = tc && cnt_en && enable && !wdt_reset;

  wdt_window_cnt #(
    .PERIOD (PERIOD),
    .CW     (CW)
  ) u_window_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = COLLECT;
      COLLECT: if (tc) state_next = all_seen ? KICK : COLLECT;
      // KICK always starts at count 0, so the window count doubles as the
      // pulse-length counter; KICK_WIDTH < PERIOD keeps it clear of tc.
      KICK:    if (cnt == CW'(KICK_WIDTH - 1)) state_next = COLLECT;
      HOLD:    if (!wdt_reset) state_next = COLLECT;
      default: state_next = IDLE;
    endcase
    if (wdt_reset) state_next = HOLD;
    if (!enable)   state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      kick_reg   <= 1'b0;
      seen_reg   <= '0;
      missed_reg <= '0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kick_reg  <= (state_next == KICK);
      if (!enable) begin
        seen_reg   <= '0;
        missed_reg <= '0;
        fault_reg  <= 1'b0;
      end else if (wdt_reset) begin
        seen_reg <= '0;
      end else if (cnt_en) begin
        seen_reg <= tc ? '0 : seen_now;
        if (win_end) begin
          if (all_seen) begin
            missed_reg <= '0;
          end else begin
            missed_reg <= ~seen_now;
            fault_reg  <= 1'b1;
          end
        end
      end
    end
  end

  assign kick   = kick_reg;
  assign missed = missed_reg;
  assign fault  = fault_reg;

`ifdef WDT_KICK_STATS_EN
  logic [7:0] kick_count_reg;
  logic [7:0] reset_count_reg;
  logic       wdt_reset_prev_reg;
  logic       kick_start;
  logic       reset_rise;

  assign kick_start = (state_next == KICK) && (state_reg != KICK);
  assign reset_rise = wdt_reset && !wdt_reset_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kick_count_reg     <= '0;
      reset_count_reg    <= '0;
      wdt_reset_prev_reg <= 1'b0;
    end else begin
      wdt_reset_prev_reg <= wdt_reset;
      if (kick_start && (kick_count_reg != 8'hFF)) begin
        kick_count_reg <= kick_count_reg + 8'd1;
      end
      if (reset_rise && (reset_count_reg != 8'hFF)) begin
        reset_count_reg <= reset_count_reg + 8'd1;
      end
    end
  end

  assign kick_count  = kick_count_reg;
  assign reset_count = reset_count_reg;
`endif

endmodule
